regfile_read_arbiter: RTL and testbench
=======================================

# regfile_read_arbiter

Round-robin arbiter that shares one 32-entry × 32-bit register-file read mux among NREQ requesters. It drives the mux address from the winning requester and registers the mux output. It returns that data to the winner with one cycle of latency. It sits between the CPU-side read clients and the mux32to1by32 read port, and supports bounded bus locking for back-to-back reads by one client.

## Interface
- NREQ, 4: number of requesters (2..8)
- LOCK_MAX, 8: maximum cycles one requester may hold a lock (1..255)
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester read request
- req_lock  in  NREQ  per-requester lock request, sampled only with req_valid at grant
- req_addr  in  5*NREQ  register address; requester i uses bits [5i+4:5i]
- req_ready  out  NREQ  one-hot grant, combinational; the transfer occurs when req_valid[i] and req_ready[i] are both high
- mux_address  out  5  address to the shared 32:1×32 mux, combinational
- mux_out  in  32  data returned by the shared mux for mux_address
- rsp_valid  out  NREQ  one-hot, registered; high the cycle after requester i's grant
- rsp_data  out  32  registered read data accompanying rsp_valid
- lock_active  out  1  registered; high while in state LOCK

## Operation
- State: `state` ∈ {ARB, LOCK}, `ptr` (log2 NREQ bits), `owner`, and `lock_cnt` (8 bits).
- ARB: eligible set = all i with req_valid[i]. Search starts at ptr and increments modulo NREQ. The first eligible requester wins.
- LOCK: the only candidate is `owner`, and only if req_valid[owner] is high. All other requesters see req_ready = 0.
- Grant i: req_ready[i] = 1, mux_address = req_addr[i]. With no grant, req_ready = 0 and mux_address = 0.
- After a grant to i, ptr ← (i+1) mod NREQ. ptr is unchanged when there is no grant.
- ARB → LOCK: granted i has req_lock[i] = 1. Then owner ← i, lock_cnt ← 1.
- LOCK stay: req_lock[owner] = 1 and lock_cnt < LOCK_MAX. lock_cnt increments every cycle in LOCK, whether or not a grant occurs.
- LOCK → ARB (release): req_lock[owner] = 0. The exit is combinational in the same cycle, so that cycle arbitrates as ARB. The same ARB rules apply, including a possible re-lock by the new winner.
- LOCK → ARB (forced): lock_cnt = LOCK_MAX at a clock edge. Then ptr ← (owner+1) mod NREQ. The owner may re-lock only through normal round-robin.
- Response: on each grant edge, rsp_data ← mux_out and rsp_valid ← onehot(i). Otherwise rsp_valid ← 0 and rsp_data holds its value.
- Requesters with req_valid = 0 are never granted, regardless of req_lock.
- Address range is the full 0..31; there are no reserved addresses.

## Timing
- Reset values: state = ARB, ptr = 0, owner = 0, lock_cnt = 0, rsp_valid = 0, rsp_data = 0, lock_active = 0.
- Combinational outputs under reset: req_ready = 0 and mux_address = 0 while reset is high.
- Latency: grant in cycle N → rsp_valid/rsp_data valid in cycle N+1.
- Throughput: one grant per cycle, fully pipelined, with no bubbles between consecutive grants.
- Reset mid-operation: any response in flight is dropped, so rsp_valid = 0 in the cycle after the reset edge. An active lock is cleared.
- Simultaneous requests from all NREQ requesters with no locks: each is served once per NREQ cycles.
- Requester drops req_valid while ready is low: this is legal, and there is no ordering obligation.

## Configuration
- Macro: `REGFILE_ARB_STATS_EN`.
- When defined, the block adds the following:
  - input `stat_sel` [2:0]
  - input `stat_clr` (1)
  - output `stat_count` [15:0]
  - one 16-bit saturating grant counter per requester, each holding at 16'hFFFF
- Counter behaviour: stat_count = counter[stat_sel], combinational. stat_sel ≥ NREQ reads 0. stat_clr zeroes all counters synchronously, and a grant in the same cycle as stat_clr is not counted. reset zeroes all counters.
- When undefined, none of these ports or counters exist and arbitration is identical.

## Test plan
- Reset check: assert reset for 2 cycles with all req_valid high → req_ready = 0, mux_address = 0, rsp_valid = 0, rsp_data = 0 throughout.
- Single read: req_valid = 4'b0100 with addr[2] = 5'd17 and mux model returning 32'hDEAD0017 → req_ready = 4'b0100 and mux_address = 17 in cycle N; rsp_valid = 4'b0100 and rsp_data = 32'hDEAD0017 in cycle N+1.
- Round-robin: all four requesters valid continuously from reset → grant order 0,1,2,3,0,1… and rsp_valid follows one cycle later.
- Lock release: req 1 valid and locked for 3 cycles, all others valid → grants 1,1,1. req_lock[1] drops in cycle 4, and that cycle grants 2 (ptr = 2).
- Forced unlock: LOCK_MAX = 8, req 0 valid and locked indefinitely, req 3 valid → 8 grants to 0, then grant 1 goes to 3 (ptr = 1, only 0 and 3 valid). lock_active falls after 8 cycles.
- Stats (REGFILE_ARB_STATS_EN): run the round-robin test for 40 cycles, then stat_sel = 2 → stat_count = 10. stat_clr for one cycle → stat_count = 0. Forcing 70000 grants → stat_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/regfile_read_arbiter_if.sv
// Requester-side bus of the register-file read arbiter: request, grant and
// one-cycle-delayed read response, flattened over NREQ requesters.
interface regfile_read_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_lock;
  logic [5*NREQ-1:0] req_addr;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_data;

  modport master (
    output req_valid, req_lock, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_lock, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter with bounded locking that shares one 32x32 register-file read mux.
// Optional per-requester grant counters are compiled in with `REGFILE_ARB_STATS_EN.
module regfile_read_arbiter #(
  parameter int NREQ     = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_read_arbiter_if.slave bus,
  output logic [4:0]            mux_address,
  input  logic [31:0]           mux_out,
  output logic                  lock_active
`ifdef REGFILE_ARB_STATS_EN
  ,
  input  logic [2:0]            stat_sel,
  input  logic                  stat_clr,
  output logic [15:0]           stat_count
`endif
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt, owner, owner_nxt;
  logic [7:0]       lock_cnt, lock_cnt_nxt;

  logic             forced, arb_mode, grant_p0;
  logic [PTR_W-1:0] base, win_p0, cand;
  logic [NREQ-1:0]  ready_p0;
  logic [4:0]       addr_arr [NREQ];

  logic [NREQ-1:0]  rsp_vld_p1;
  logic [31:0]      rsp_data_p1;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] i);
    wrap_inc = (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_arr[g] = bus.req_addr[5*g +: 5];
  end

  // Stage p0: pick the winner and drive the shared mux address
  always_comb begin
    // Hitting the lock limit behaves like a release, but search resumes after the owner
    forced   = (state == ST_LOCK) && (lock_cnt >= 8'(LOCK_MAX));
    arb_mode = (state == ST_ARB) || forced || !bus.req_lock[owner];
    base     = forced ? wrap_inc(owner) : ptr;
    grant_p0 = 1'b0;
    win_p0   = owner;
    cand     = '0;
    if (!reset) begin
      if (arb_mode) begin
        for (int k = 0; k < NREQ; k++) begin
          cand = PTR_W'((int'(base) + k) % NREQ);
          if (!grant_p0 && bus.req_valid[cand]) begin
            grant_p0 = 1'b1;
            win_p0   = cand;
          end
        end
      end else begin
        grant_p0 = bus.req_valid[owner];
      end
    end
    ready_p0    = '0;
    mux_address = 5'd0;
    if (grant_p0) begin
      ready_p0[win_p0] = 1'b1;
      mux_address      = addr_arr[win_p0];
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    if (arb_mode) begin
      ptr_nxt = grant_p0 ? wrap_inc(win_p0) : base;
      if (grant_p0 && bus.req_lock[win_p0]) begin
        state_nxt    = ST_LOCK;
        owner_nxt    = win_p0;
        lock_cnt_nxt = 8'd1;
      end else begin
        state_nxt    = ST_ARB;
        lock_cnt_nxt = 8'd0;
      end
    end else begin
      state_nxt    = ST_LOCK;
      lock_cnt_nxt = lock_cnt + 8'd1;
      if (grant_p0) ptr_nxt = wrap_inc(owner);
    end
  end

  // Stage p1: registered read response
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_ARB;
      ptr         <= '0;
      owner       <= '0;
      lock_cnt    <= 8'd0;
      rsp_vld_p1  <= '0;
      rsp_data_p1 <= 32'd0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      owner      <= owner_nxt;
      lock_cnt   <= lock_cnt_nxt;
      rsp_vld_p1 <= ready_p0;
      if (grant_p0) rsp_data_p1 <= mux_out;
    end
  end

  assign bus.req_ready = ready_p0;
  assign bus.rsp_valid = rsp_vld_p1;
  assign bus.rsp_data  = rsp_data_p1;
  assign lock_active   = (state == ST_LOCK);

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] stat_cnt [NREQ];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset || stat_clr)
        stat_cnt[i] <= 16'd0;
      else if (grant_p0 && (int'(win_p0) == i))
        stat_cnt[i] <= sat_inc(stat_cnt[i]);
    end
  end

  always_comb begin
    stat_count = 16'd0;
    for (int i = 0; i < NREQ; i++)
      if (int'(stat_sel) == i) stat_count = stat_cnt[i];
  end
`endif

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter (NREQ=4, LOCK_MAX=8) with a BCD-tagged mux model;
// stat checks are included when REGFILE_ARB_STATS_EN is defined.
module tb_regfile_read_arbiter;
  logic        clk;
  logic        reset;
  logic [4:0]  mux_address;
  logic [31:0] mux_out;
  logic        lock_active;
  int          n_pass;
  int          n_total;
`ifdef REGFILE_ARB_STATS_EN
  logic [2:0]  stat_sel;
  logic        stat_clr;
  logic [15:0] stat_count;
`endif

  regfile_read_arbiter_if #(.NREQ(4)) bus ();

  regfile_read_arbiter #(.NREQ(4), .LOCK_MAX(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .mux_address (mux_address),
    .mux_out     (mux_out),
    .lock_active (lock_active)
`ifdef REGFILE_ARB_STATS_EN
    ,
    .stat_sel    (stat_sel),
    .stat_clr    (stat_clr),
    .stat_count  (stat_count)
`endif
  );

  // Register a holds 0xDEAD00 followed by a in two decimal digits
  function automatic logic [31:0] mdl(input int a);
    mdl = 32'hDEAD0000 | 32'((a / 10) << 4) | 32'(a % 10);
  endfunction

  assign mux_out = mdl(int'(mux_address));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    clk     = 1'b0;
    reset   = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_lock  = 4'b0000;
    bus.req_addr  = {5'd27, 5'd19, 5'd11, 5'd3};
`ifdef REGFILE_ARB_STATS_EN
    stat_sel = 3'd0;
    stat_clr = 1'b0;
`endif

    // Reset held two cycles with every requester asking
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ready", 32'(bus.req_ready), 32'h0);
      chk("rst_addr",  32'(mux_address),   32'h0);
      chk("rst_rspv",  32'(bus.rsp_valid), 32'h0);
      chk("rst_rspd",  bus.rsp_data,       32'h0);
      chk("rst_lock",  32'(lock_active),   32'h0);
    end

    // Round-robin from reset, all four valid
    reset = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_ready", 32'(bus.req_ready), 32'(4'b0001 << (k % 4)));
      chk("rr_addr",  32'(mux_address),   32'(8 * (k % 4) + 3));
      if (k > 0) begin
        chk("rr_rspv", 32'(bus.rsp_valid), 32'(4'b0001 << ((k - 1) % 4)));
        chk("rr_rspd", bus.rsp_data,       mdl(8 * ((k - 1) % 4) + 3));
      end
      tick();
    end
    chk("rr_last_rspv", 32'(bus.rsp_valid), 32'h8);
    chk("rr_last_rspd", bus.rsp_data,       mdl(27));

    // Reset mid-stream drops the in-flight response
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(bus.req_ready), 32'h0);
    chk("midrst_addr",  32'(mux_address),   32'h0);
    tick();
    chk("midrst_rspv", 32'(bus.rsp_valid), 32'h0);

    // Single read from requester 2
    reset = 1'b0;
    bus.req_valid = 4'b0100;
    bus.req_addr[14:10] = 5'd17;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'h4);
    chk("single_addr",  32'(mux_address),   32'd17);
    tick();
    bus.req_valid = 4'b0000;
    #1;
    chk("single_rspv",  32'(bus.rsp_valid), 32'h4);
    chk("single_rspd",  bus.rsp_data,       32'hDEAD0017);
    chk("single_idle",  32'(bus.req_ready), 32'h0);
    tick();
    chk("single_rspv0", 32'(bus.rsp_valid), 32'h0);
    chk("single_hold",  bus.rsp_data,       32'hDEAD0017);

    // Lock release: ptr is 3, grant 0 first, then 1 locks for three cycles
    bus.req_valid = 4'b0001;
    #1;
    chk("lr_pre", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 4'b1111;
    bus.req_lock  = 4'b0010;
    #1;
    chk("lr_g0", 32'(bus.req_ready), 32'h2);
    chk("lr_la0", 32'(lock_active), 32'h0);
    tick();
    chk("lr_la1", 32'(lock_active), 32'h1);
    chk("lr_g1", 32'(bus.req_ready), 32'h2);
    tick();
    chk("lr_g2", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_lock = 4'b0000;
    #1;
    chk("lr_release", 32'(bus.req_ready), 32'h4);
    chk("lr_rel_addr", 32'(mux_address), 32'd17);
    tick();
    chk("lr_la_off", 32'(lock_active), 32'h0);
    chk("lr_rspv", 32'(bus.rsp_valid), 32'h4);
    chk("lr_rspd", bus.rsp_data, mdl(17));

    // Forced unlock after LOCK_MAX cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid = 4'b1001;
    bus.req_lock  = 4'b0001;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk("fu_ready", 32'(bus.req_ready), (c == 8) ? 32'h8 : 32'h1);
      chk("fu_lock",  32'(lock_active),   (c >= 1 && c <= 8) ? 32'h1 : 32'h0);
      tick();
    end
    chk("fu_relock", 32'(lock_active), 32'h1);

`ifdef REGFILE_ARB_STATS_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_lock  = 4'b0000;
    stat_sel = 3'd2;
    repeat (40) tick();
    chk("stat_rr", 32'(stat_count), 32'd10);
    stat_sel = 3'd5;
    #1;
    chk("stat_oob", 32'(stat_count), 32'd0);
    stat_sel = 3'd2;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    bus.req_valid = 4'b0000;
    #1;
    chk("stat_clr2", 32'(stat_count), 32'd0);
    stat_sel = 3'd3;
    #1;
    chk("stat_clr3", 32'(stat_count), 32'd0);
    bus.req_valid = 4'b0001;
    stat_sel = 3'd0;
    repeat (65600) tick();
    chk("stat_sat", 32'(stat_count), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
